ppu_oam: RTL
============

Name: ppu_oam

Overview:
- Primary sprite attribute memory (OAM, 256x8) and PPU sprite-evaluation engine.
- Sits directly downstream of the sprite DMA block. It receives the OAMADDR (0x2003) and OAMDATA (0x2004) register writes that the DMA and CPU issue through the PPU register interface.
- Once per scanline it scans all 64 sprites and fills an 8-entry secondary OAM, which the sprite fetch/render logic reads.

Parameters:
- SOAM_SLOTS, 8, number of secondary OAM sprite slots; counters sized for 8.

Ports:
- clk_in input 1: system clock (50MHz).
- rst_in input 1: reset, asynchronous, active-high.
- ri_sel_in input 3: PPU register select (3=OAMADDR, 4=OAMDATA; others ignored).
- ri_ncs_in input 1: register chip select, active low.
- ri_r_nw_in input 1: 1=read, 0=write.
- ri_d_in input 8: register write data.
- ri_d_out output 8: OAMDATA read data.
- eval_start_in input 1: one-cycle pulse that begins sprite evaluation.
- scanline_in input 8: target scanline (0-239), sampled on eval_start_in.
- spr_h_in input 1: sprite height, 0=8px, 1=16px; sampled on eval_start_in.
- eval_busy_out output 1: evaluation in progress.
- eval_done_out output 1: one-cycle pulse when evaluation completes.
- soam_cnt_out output 4: sprites found, 0-8.
- overflow_out output 1: more than 8 sprites in range.
- spr0_in_out output 1: sprite 0 occupies secondary slot 0.
- soam_a_in input 5: secondary OAM read address ({slot[2:0], byte[1:0]}).
- soam_d_out output 8: secondary OAM read data, combinational.

Behaviour:
- Access strobe: a register access fires on the cycle ri_ncs_in is low and the registered copy of ri_ncs_in is high (falling edge). Exactly one action per chip-select assertion.
- Write sel 3: oam_addr <= ri_d_in.
- Write sel 4: oam[oam_addr] <= ri_d_in; oam_addr <= oam_addr+1, wrapping 0xFF->0x00.
- Read sel 4: no increment.
- ri_d_out = oam[oam_addr] combinationally whenever ri_ncs_in=0, ri_r_nw_in=1 and ri_sel_in=4. Otherwise 8'h00.
- The DMA pattern (write 0x2003=0x00, then 256 writes to 0x2004) fills oam[0..255] in order and leaves oam_addr=0x00.
- Reset: oam_addr=0, state=IDLE, soam all 0xFF, soam_cnt_out=0, overflow_out=0, spr0_in_out=0, eval_busy_out=0, eval_done_out=0.
- Reset does NOT clear primary OAM contents.
- FSM states: IDLE, CLEAR, SCAN, COPY, DONE.
- IDLE: on eval_start_in, latch scanline and height, clear cnt/overflow/spr0, n=0, go to CLEAR.
- CLEAR: write 0xFF to soam[0..31], one byte per cycle (32 cycles), then go to SCAN.
- SCAN: one cycle per sprite n. diff = {1'b0,scanline} - {1'b0,oam[4n]} (9-bit). In range iff diff[8]==0 and diff[7:0] < (spr_h ? 16 : 8).
  - In range and cnt<8: go to COPY.
  - In range and cnt==8: overflow_out=1, go to DONE.
  - Not in range: n=n+1; after n=63, go to DONE.
- COPY: 4 cycles copying oam[4n+0..3] to soam[{cnt,0..3}]. Then cnt=cnt+1; spr0 set if n==0. Then n+1, or DONE if n==63.
- DONE: eval_done_out=1 for one cycle, eval_busy_out=0, return to IDLE. Results hold until the next eval_start_in.
- Worst case: 32+64+8*4+1 = 129 cycles.
- eval_busy_out=1 in CLEAR/SCAN/COPY.
- eval_start_in while busy restarts from CLEAR with newly sampled inputs.
- A CPU/DMA write during evaluation takes effect immediately. An eval read of the same byte in the same cycle sees the old value. There is no stall or hang.
- Y=0xFF is never in range for scanline 0-239.

Optional Feature:
- OAM_ATTR_MASK_EN: when defined, OAMDATA reads where oam_addr[1:0]==2 return bits [4:2] as 0 (unimplemented 2C02 attribute bits). The copy to secondary OAM also masks these bits.
- When undefined, stored values are returned and copied unmodified.

Test Plan:
- Write 0x2003=0x00, then 256 writes 0x2004 with data=addr -> oam[i]=i; oam_addr=0x00; read sel 4 returns 0x00 twice, with no increment.
- Write 0x2003=0xFE, then 3 writes 0x2004 (A,B,C) -> oam[FE]=A, oam[FF]=B, oam[00]=C; oam_addr=0x01.
- All Y=0xFF; sprite 5 Y=10; scanline=17, 8px -> cnt=1, soam[0..3]=oam[20..23], soam[4..31]=0xFF, overflow=0, spr0=0.
- All 64 sprites Y=0, scanline=3 -> cnt=8, overflow=1, spr0=1, done pulse once. Same with scanline=12: 8px gives cnt=0; 16px gives cnt=8.
- Assert rst_in mid-COPY -> outputs return immediately to reset values; primary OAM unchanged. A new eval_start_in then completes normally.
- With OAM_ATTR_MASK_EN: write 0xFF to oam[2] -> read returns 0xE3, soam byte 2 = 0xE3. Without the macro -> 0xFF.

Source files
------------

// File: rtl/ppu_oam.sv
// ppu_oam - primary sprite attribute memory (256x8) and the per-scanline
// sprite-evaluation engine that fills an 8-slot secondary OAM.
//
// Optional feature macro: OAM_ATTR_MASK_EN
//   When defined, attribute bytes (address[1:0] == 2) read through OAMDATA
//   or copied into secondary OAM have bits [4:2] forced to 0.
//
// Ports:
//   clk_in, rst_in           clock, asynchronous active-high reset
//   ri_sel_in/ri_ncs_in/
//   ri_r_nw_in/ri_d_in       PPU register interface (3=OAMADDR, 4=OAMDATA)
//   ri_d_out                 OAMDATA read data (combinational, 0 when idle)
//   eval_start_in            pulse starting (or restarting) an evaluation
//   scanline_in, spr_h_in    target scanline and sprite height, sampled on start
//   eval_busy_out            evaluation in progress (CLEAR/SCAN/COPY)
//   eval_done_out            one-cycle completion pulse
//   soam_cnt_out             sprites found (0-8)
//   overflow_out             a ninth in-range sprite was seen
//   spr0_in_out              sprite 0 sits in secondary slot 0
//   soam_a_in, soam_d_out    secondary OAM read port (combinational)
module ppu_oam #(
  parameter int SOAM_SLOTS = 8
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [2:0] ri_sel_in,
  input  logic       ri_ncs_in,
  input  logic       ri_r_nw_in,
  input  logic [7:0] ri_d_in,
  output logic [7:0] ri_d_out,
  input  logic       eval_start_in,
  input  logic [7:0] scanline_in,
  input  logic       spr_h_in,
  output logic       eval_busy_out,
  output logic       eval_done_out,
  output logic [3:0] soam_cnt_out,
  output logic       overflow_out,
  output logic       spr0_in_out,
  input  logic [4:0] soam_a_in,
  output logic [7:0] soam_d_out
);

`ifdef OAM_ATTR_MASK_EN
  localparam logic ATTR_MASK = 1'b1;
`else
  localparam logic ATTR_MASK = 1'b0;
`endif

  // Attribute byte bits [4:2] do not exist on the real part.
  function automatic logic [7:0] attr_mask(input logic [7:0] d, input logic [1:0] idx);
    if (ATTR_MASK && (idx == 2'd2)) begin
      return d & 8'hE3;
    end else begin
      return d;
    end
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_SCAN  = 3'd2,
    ST_COPY  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t      state;
  state_t      next_state;

  logic [7:0]  oam [0:255];
  logic [7:0]  soam [0:31];

  logic [7:0]  oam_addr;
  logic        ncs_q;
  logic        access;
  logic        oam_we;

  logic [5:0]  n;
  logic [4:0]  idx;
  logic [3:0]  cnt;
  logic [7:0]  scan_line;
  logic        spr_h;
  logic        overflow;
  logic        spr0;
  logic        busy;
  logic        done;

  logic [7:0]  spr_y;
  logic [8:0]  diff;
  logic        in_range;
  logic [7:0]  copy_byte;
  logic        slot_free;

  // One action per chip-select assertion: fire on the falling edge of ncs.
  assign access = ~ri_ncs_in & ncs_q;
  assign oam_we = access & ~ri_r_nw_in & (ri_sel_in == 3'd4);

  // Register-interface state: chip-select history and the OAM address pointer.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ncs_q    <= 1'b1;
      oam_addr <= 8'h00;
    end else begin
      ncs_q <= ri_ncs_in;
      if (access && !ri_r_nw_in) begin
        case (ri_sel_in)
          3'd3:    oam_addr <= ri_d_in;
          3'd4:    oam_addr <= oam_addr + 8'd1;
          default: oam_addr <= oam_addr;
        endcase
      end else begin
        oam_addr <= oam_addr;
      end
    end
  end

  // Primary OAM write port; contents deliberately survive reset.
  always_ff @(posedge clk_in) begin
    if (oam_we) begin
      oam[oam_addr] <= ri_d_in;
    end
  end

  // OAMDATA read path, driven only during an active read of register 4.
  always_comb begin
    ri_d_out = 8'h00;
    if (!ri_ncs_in && ri_r_nw_in && (ri_sel_in == 3'd4)) begin
      ri_d_out = attr_mask(oam[oam_addr], oam_addr[1:0]);
    end else begin
      ri_d_out = 8'h00;
    end
  end

  // Range test for the sprite under evaluation. A Y above the scanline
  // borrows into diff[8]; Y=0xFF can never be in range for lines 0-239.
  always_comb begin
    spr_y     = oam[{n, 2'b00}];
    diff      = {1'b0, scan_line} - {1'b0, spr_y};
    in_range  = 1'b0;
    if (!diff[8]) begin
      in_range = (diff[7:0] < (spr_h ? 8'd16 : 8'd8));
    end else begin
      in_range = 1'b0;
    end
    slot_free = (cnt < 4'(SOAM_SLOTS));
    copy_byte = attr_mask(oam[{n, idx[1:0]}], idx[1:0]);
  end

  // FSM state register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic; a start pulse always (re)starts from CLEAR.
  always_comb begin
    next_state = state;
    if (eval_start_in) begin
      next_state = ST_CLEAR;
    end else begin
      case (state)
        ST_IDLE: next_state = ST_IDLE;
        ST_CLEAR: begin
          if (idx == 5'd31) begin
            next_state = ST_SCAN;
          end else begin
            next_state = ST_CLEAR;
          end
        end
        ST_SCAN: begin
          if (in_range) begin
            next_state = slot_free ? ST_COPY : ST_DONE;
          end else if (n == 6'd63) begin
            next_state = ST_DONE;
          end else begin
            next_state = ST_SCAN;
          end
        end
        ST_COPY: begin
          if (idx[1:0] == 2'd3) begin
            next_state = (n == 6'd63) ? ST_DONE : ST_SCAN;
          end else begin
            next_state = ST_COPY;
          end
        end
        ST_DONE: next_state = ST_IDLE;
        default: next_state = ST_IDLE;
      endcase
    end
  end

  // Evaluation datapath: counters, secondary OAM and registered status flags.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      n         <= 6'd0;
      idx       <= 5'd0;
      cnt       <= 4'd0;
      scan_line <= 8'd0;
      spr_h     <= 1'b0;
      overflow  <= 1'b0;
      spr0      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        soam[i] <= 8'hFF;
      end
    end else begin
      done <= (next_state == ST_DONE);
      busy <= (next_state == ST_CLEAR) || (next_state == ST_SCAN) ||
              (next_state == ST_COPY);
      if (eval_start_in) begin
        scan_line <= scanline_in;
        spr_h     <= spr_h_in;
        cnt       <= 4'd0;
        overflow  <= 1'b0;
        spr0      <= 1'b0;
        n         <= 6'd0;
        idx       <= 5'd0;
      end else begin
        case (state)
          ST_CLEAR: begin
            soam[idx] <= 8'hFF;
            idx       <= idx + 5'd1;   // wraps to 0, ready for the first COPY
          end
          ST_SCAN: begin
            if (in_range && slot_free) begin
              idx <= 5'd0;
            end else if (in_range) begin
              overflow <= 1'b1;
            end else begin
              n <= n + 6'd1;
            end
          end
          ST_COPY: begin
            soam[{cnt[2:0], idx[1:0]}] <= copy_byte;
            if (idx[1:0] == 2'd3) begin
              idx <= 5'd0;
              cnt <= cnt + 4'd1;
              n   <= n + 6'd1;
              if (n == 6'd0) begin
                spr0 <= 1'b1;
              end else begin
                spr0 <= spr0;
              end
            end else begin
              idx <= idx + 5'd1;
            end
          end
          default: begin
            idx <= idx;
          end
        endcase
      end
    end
  end

  assign eval_busy_out = busy;
  assign eval_done_out = done;
  assign soam_cnt_out  = cnt;
  assign overflow_out  = overflow;
  assign spr0_in_out   = spr0;
  assign soam_d_out    = soam[soam_a_in];

endmodule
